paridad_gen_chk: RTL and testbench
==================================

# paridad_gen_chk

Parametrised, registered parity generator and checker with a valid/ready handshake and an optional error counter. It accepts DATA_W-bit words and appends an even or odd parity bit, selected per word. In check mode it also compares a received parity bit against the computed one and flags mismatches. It sits between a word source and the serialiser/deserialiser stage, and supersedes the fixed 7-bit combinational parity generator.

## Interface
Parameters:
- DATA_W, 7, payload width in bits (≥1)
- CNT_W, 8, error-counter width in bits (≥1)

Ports:
- clk  input  1  single clock; all logic on rising edge
- reset  input  1  synchronous, active-high reset
- in_valid  input  1  input word present
- in_ready  output  1  block can accept this cycle
- in_data  input  DATA_W  payload
- in_par  input  1  received parity bit; used only when in_chk=1
- in_chk  input  1  1 = check in_par against computed parity; 0 = generate only
- parimpar  input  1  parity mode: 0 = even, 1 = odd; sampled per word
- out_valid  output  1  output word present
- out_ready  input  1  downstream accepts
- out_data  output  DATA_W+1  {parity, payload}; parity is the MSB
- out_err  output  1  parity mismatch for the presented word (0 when in_chk was 0)
- clr_cnt  input  1  synchronous clear of err_cnt
- err_cnt  output  CNT_W  saturating mismatch count

## Operation
- Computed parity is ^in_data ^ parimpar. Even mode makes the total count of ones in out_data even; odd mode makes it odd.
- Accept condition: in_valid && in_ready.
- in_ready = !out_valid || out_ready. This is a single-entry output register; a new word can be accepted in the same cycle the held word is consumed.
- On accept, the following are registered together, and out_valid is set:
  - out_data <= {parity, in_data}
  - out_err <= in_chk && (in_par != parity)
- When out_valid && out_ready with no accept, out_valid clears. out_data and out_err then hold their last values.
- While out_valid=1 && out_ready=0, out_data and out_err are stable. Input changes have no effect.
- parimpar, in_chk and in_par matter only in the accept cycle.
- err_cnt:
  - Increments by 1 in each accept cycle with a mismatch.
  - Saturates at 2^CNT_W−1; no wrap.
  - clr_cnt has priority: when clr_cnt=1, err_cnt <= 0 even if a mismatch is accepted in the same cycle.

## Timing
- Latency is 1 cycle: a word accepted at edge N is presented with out_valid=1 after edge N.
- Throughput is 1 word/cycle while out_ready=1.
- The err_cnt update is visible after the same edge that raises out_valid for the erroneous word.
- Reset values: out_valid=0, out_data=0, out_err=0, err_cnt=0.
- in_ready=1 after reset, because it is combinational from out_valid and out_ready.
- Reset mid-transfer discards the held word; no output handshake occurs for it.
- Reset has priority over every other input, including clr_cnt and accept.
- in_ready depends combinationally only on out_valid and out_ready. There is no path from in_valid to in_ready.

## Configuration
- Macro: PARIDAD_ERR_CNT_EN.
- Defined: the err_cnt register, saturation and clr_cnt logic are built as described.
- Undefined:
  - err_cnt is driven constant 0 and clr_cnt is ignored.
  - out_err is still generated.
  - Handshake and data behaviour are identical.

## Test plan
- Generate, even mode: DATA_W=7, in_data=7'h55, parimpar=0, out_ready=1 → one cycle later out_data=8'h55, out_err=0. Same word with parimpar=1 → out_data=8'hD5.
- Back-pressure:
  - Hold out_ready=0 and send 7'h01 then 7'h03 → in_ready=0 after the first accept, and out_data stays 8'h81 (even mode).
  - Raise out_ready → the next cycle out_data=8'h03.
- Check mismatch: in_chk=1, in_data=7'h01, in_par=0, even mode → out_err=1 and err_cnt=1. Repeat with in_par=1 → out_err=0 and err_cnt stays 1.
- Saturation and clear:
  - CNT_W=2, five back-to-back mismatches → err_cnt sequence 1,2,3,3,3.
  - clr_cnt=1 in the same cycle as a sixth mismatch → err_cnt=0.
- Reset mid-operation:
  - Stall a word with out_ready=0, then assert reset for 1 cycle → out_valid=0, out_data=0, err_cnt=0, in_ready=1.
  - The next accepted word appears normally.
- Macro off: rerun the check-mismatch scenario → out_err identical to the macro-on run, err_cnt=0 throughout.

Source files
------------

// File: rtl/paridad_gen_chk.sv
// ---------------------------------------------------------------------------
// paridad_gen_chk
//
// Registered parity generator/checker with a single-entry valid/ready output
// stage. Each accepted word gets a parity bit prepended (even or odd, chosen
// per word). In check mode the received parity bit is compared against the
// computed one and a mismatch flag travels with the word.
//
// Optional feature macro: PARIDAD_ERR_CNT_EN
//   defined   -> saturating mismatch counter err_cnt with synchronous clear
//   undefined -> err_cnt tied to 0, clr_cnt ignored
//
// Parameters:
//   DATA_W  payload width in bits (>= 1)
//   CNT_W   error counter width in bits (>= 1)
//
// Ports:
//   clk        clock, rising edge
//   reset      synchronous active-high reset
//   in_valid   input word present
//   in_ready   block can accept this cycle (depends only on output stage)
//   in_data    payload
//   in_par     received parity bit, used when in_chk = 1
//   in_chk     1 = check in_par, 0 = generate only
//   parimpar   0 = even parity, 1 = odd parity
//   out_valid  output word present
//   out_ready  downstream accepts
//   out_data   {parity, payload}
//   out_err    parity mismatch flag for the presented word
//   clr_cnt    synchronous clear of err_cnt
//   err_cnt    saturating mismatch count
// ---------------------------------------------------------------------------
module paridad_gen_chk #(
    parameter int DATA_W = 7,
    parameter int CNT_W  = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_par,
    input  logic              in_chk,
    input  logic              parimpar,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W:0]   out_data,
    output logic              out_err,
    input  logic              clr_cnt,
    output logic [CNT_W-1:0]  err_cnt
);

    logic            validQ, validD;
    logic [DATA_W:0] dataQ, dataD;
    logic            errQ, errD;

    logic parityBit;
    logic accept;
    logic mismatch;

    // XOR-reduce the payload and fold in the mode bit: odd mode flips the
    // parity so that the total count of ones in out_data comes out odd.
    assign parityBit = (^in_data) ^ parimpar;
    assign mismatch  = in_chk && (in_par != parityBit);

    // The output register can take a new word when it is empty or when the
    // word it holds leaves in this same cycle; no dependence on in_valid.
    assign in_ready = !validQ || out_ready;
    assign accept   = in_valid && in_ready;

    // Next state of the output stage. Data and error flag only move on an
    // accept, so they stay stable while stalled and hold after draining.
    always_comb begin
        validD = validQ;
        dataD  = dataQ;
        errD   = errQ;
        if (accept) begin
            validD = 1'b1;
            dataD  = {parityBit, in_data};
            errD   = mismatch;
        end else if (validQ && out_ready) begin
            validD = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            validQ <= 1'b0;
            dataQ  <= '0;
            errQ   <= 1'b0;
        end else begin
            validQ <= validD;
            dataQ  <= dataD;
            errQ   <= errD;
        end
    end

    assign out_valid = validQ;
    assign out_data  = dataQ;
    assign out_err   = errQ;

`ifdef PARIDAD_ERR_CNT_EN
    logic [CNT_W-1:0] cntQ, cntD;

    // Clear wins over a same-cycle mismatch; the count sticks at all ones.
    always_comb begin
        cntD = cntQ;
        if (clr_cnt) begin
            cntD = '0;
        end else if (accept && mismatch && (cntQ != {CNT_W{1'b1}})) begin
            cntD = cntQ + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cntQ <= '0;
        end else begin
            cntQ <= cntD;
        end
    end

    assign err_cnt = cntQ;
`else
    // Counter not built: clr_cnt has no function in this configuration.
    logic unused_clr_cnt;
    assign unused_clr_cnt = clr_cnt;
    assign err_cnt        = '0;
`endif

endmodule

// File: tb/tb_paridad_gen_chk.sv
// ---------------------------------------------------------------------------
// tb_paridad_gen_chk
//
// Directed testbench for paridad_gen_chk with DATA_W = 7, CNT_W = 2.
// Expected err_cnt values follow the PARIDAD_ERR_CNT_EN macro: with the
// counter built they track mismatches, otherwise they are always 0.
// ---------------------------------------------------------------------------
module tb_paridad_gen_chk;

    localparam int DATA_W = 7;
    localparam int CNT_W  = 2;

`ifdef PARIDAD_ERR_CNT_EN
    localparam bit CntEn = 1'b1;
`else
    localparam bit CntEn = 1'b0;
`endif

    logic              clk = 1'b0;
    logic              reset;
    logic              inValid;
    logic              inReady;
    logic [DATA_W-1:0] inData;
    logic              inPar;
    logic              inChk;
    logic              parImpar;
    logic              outValid;
    logic              outReady;
    logic [DATA_W:0]   outData;
    logic              outErr;
    logic              clrCnt;
    logic [CNT_W-1:0]  errCnt;

    int compared   = 0;
    int mismatched = 0;

    paridad_gen_chk #(
        .DATA_W(DATA_W),
        .CNT_W (CNT_W)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .in_valid (inValid),
        .in_ready (inReady),
        .in_data  (inData),
        .in_par   (inPar),
        .in_chk   (inChk),
        .parimpar (parImpar),
        .out_valid(outValid),
        .out_ready(outReady),
        .out_data (outData),
        .out_err  (outErr),
        .clr_cnt  (clrCnt),
        .err_cnt  (errCnt)
    );

    always #5 clk = ~clk;

    // Advance one rising edge and settle 1 time unit past it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [CNT_W-1:0] expCnt(input int n);
        return CntEn ? CNT_W'(n) : '0;
    endfunction

    task automatic test_reset();
        reset    = 1'b1;
        inValid  = 1'b0;
        inData   = '0;
        inPar    = 1'b0;
        inChk    = 1'b0;
        parImpar = 1'b0;
        outReady = 1'b1;
        clrCnt   = 1'b0;
        tick();
        tick();
        reset = 1'b0;
        compared++;
        if (outValid !== 1'b0) begin mismatched++; $display("[TB] FAIL reset out_valid: got %b want 0", outValid); end
        compared++;
        if (outData !== 8'h00) begin mismatched++; $display("[TB] FAIL reset out_data: got %h want 00", outData); end
        compared++;
        if (outErr !== 1'b0) begin mismatched++; $display("[TB] FAIL reset out_err: got %b want 0", outErr); end
        compared++;
        if (errCnt !== 2'd0) begin mismatched++; $display("[TB] FAIL reset err_cnt: got %0d want 0", errCnt); end
        compared++;
        if (inReady !== 1'b1) begin mismatched++; $display("[TB] FAIL reset in_ready: got %b want 1", inReady); end
    endtask

    task automatic test_generate();
        outReady = 1'b1;
        inValid  = 1'b1;
        inChk    = 1'b0;
        inData   = 7'h55;
        parImpar = 1'b0;
        tick();
        compared++;
        if (outValid !== 1'b1) begin mismatched++; $display("[TB] FAIL gen_even out_valid: got %b want 1", outValid); end
        compared++;
        if (outData !== 8'h55) begin mismatched++; $display("[TB] FAIL gen_even out_data: got %h want 55", outData); end
        compared++;
        if (outErr !== 1'b0) begin mismatched++; $display("[TB] FAIL gen_even out_err: got %b want 0", outErr); end
        parImpar = 1'b1;
        tick();
        compared++;
        if (outData !== 8'hD5) begin mismatched++; $display("[TB] FAIL gen_odd out_data: got %h want d5", outData); end
        inValid = 1'b0;
        tick();
        compared++;
        if (outValid !== 1'b0) begin mismatched++; $display("[TB] FAIL gen_drain out_valid: got %b want 0", outValid); end
        compared++;
        if (outData !== 8'hD5) begin mismatched++; $display("[TB] FAIL gen_hold out_data: got %h want d5", outData); end
    endtask

    task automatic test_back_pressure();
        outReady = 1'b0;
        inValid  = 1'b1;
        inChk    = 1'b0;
        parImpar = 1'b0;
        inData   = 7'h01;
        tick();
        compared++;
        if (outData !== 8'h81) begin mismatched++; $display("[TB] FAIL bp_first out_data: got %h want 81", outData); end
        compared++;
        if (inReady !== 1'b0) begin mismatched++; $display("[TB] FAIL bp_first in_ready: got %b want 0", inReady); end
        inData   = 7'h03;
        parImpar = 1'b1;
        inChk    = 1'b1;
        tick();
        tick();
        compared++;
        if (outData !== 8'h81) begin mismatched++; $display("[TB] FAIL bp_stall out_data: got %h want 81", outData); end
        compared++;
        if (outValid !== 1'b1) begin mismatched++; $display("[TB] FAIL bp_stall out_valid: got %b want 1", outValid); end
        compared++;
        if (outErr !== 1'b0) begin mismatched++; $display("[TB] FAIL bp_stall out_err: got %b want 0", outErr); end
        parImpar = 1'b0;
        inChk    = 1'b0;
        outReady = 1'b1;
        #1;
        compared++;
        if (inReady !== 1'b1) begin mismatched++; $display("[TB] FAIL bp_release in_ready: got %b want 1", inReady); end
        tick();
        compared++;
        if (outData !== 8'h03) begin mismatched++; $display("[TB] FAIL bp_second out_data: got %h want 03", outData); end
        inValid = 1'b0;
        tick();
        compared++;
        if (outValid !== 1'b0) begin mismatched++; $display("[TB] FAIL bp_drain out_valid: got %b want 0", outValid); end
    endtask

    task automatic test_check();
        outReady = 1'b1;
        inValid  = 1'b1;
        inChk    = 1'b1;
        parImpar = 1'b0;
        inData   = 7'h01;
        inPar    = 1'b0;
        tick();
        compared++;
        if (outErr !== 1'b1) begin mismatched++; $display("[TB] FAIL chk_bad out_err: got %b want 1", outErr); end
        compared++;
        if (outData !== 8'h81) begin mismatched++; $display("[TB] FAIL chk_bad out_data: got %h want 81", outData); end
        compared++;
        if (errCnt !== expCnt(1)) begin mismatched++; $display("[TB] FAIL chk_bad err_cnt: got %0d want %0d", errCnt, expCnt(1)); end
        inPar = 1'b1;
        tick();
        compared++;
        if (outErr !== 1'b0) begin mismatched++; $display("[TB] FAIL chk_good out_err: got %b want 0", outErr); end
        compared++;
        if (errCnt !== expCnt(1)) begin mismatched++; $display("[TB] FAIL chk_good err_cnt: got %0d want %0d", errCnt, expCnt(1)); end
        inValid = 1'b0;
        inChk   = 1'b0;
        tick();
    endtask

    task automatic test_saturation();
        logic [CNT_W-1:0] seq [5];
        seq = '{expCnt(1), expCnt(2), expCnt(3), expCnt(3), expCnt(3)};
        clrCnt = 1'b1;
        tick();
        clrCnt = 1'b0;
        compared++;
        if (errCnt !== 2'd0) begin mismatched++; $display("[TB] FAIL sat_clear err_cnt: got %0d want 0", errCnt); end
        outReady = 1'b1;
        inValid  = 1'b1;
        inChk    = 1'b1;
        parImpar = 1'b1;
        inData   = 7'h03;
        inPar    = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            compared++;
            if (errCnt !== seq[i]) begin mismatched++; $display("[TB] FAIL sat_step%0d err_cnt: got %0d want %0d", i, errCnt, seq[i]); end
            compared++;
            if (outErr !== 1'b1) begin mismatched++; $display("[TB] FAIL sat_step%0d out_err: got %b want 1", i, outErr); end
        end
        clrCnt = 1'b1;
        tick();
        clrCnt = 1'b0;
        compared++;
        if (errCnt !== 2'd0) begin mismatched++; $display("[TB] FAIL sat_clr_prio err_cnt: got %0d want 0", errCnt); end
        compared++;
        if (outErr !== 1'b1) begin mismatched++; $display("[TB] FAIL sat_clr_prio out_err: got %b want 1", outErr); end
        inValid = 1'b0;
        inChk   = 1'b0;
        tick();
    endtask

    task automatic test_reset_mid();
        outReady = 1'b0;
        inValid  = 1'b1;
        inChk    = 1'b1;
        parImpar = 1'b0;
        inData   = 7'h7F;
        inPar    = 1'b0;
        tick();
        compared++;
        if (outData !== 8'hFF) begin mismatched++; $display("[TB] FAIL rmid_stall out_data: got %h want ff", outData); end
        compared++;
        if (errCnt !== expCnt(1)) begin mismatched++; $display("[TB] FAIL rmid_stall err_cnt: got %0d want %0d", errCnt, expCnt(1)); end
        inValid = 1'b0;
        inChk   = 1'b0;
        clrCnt  = 1'b0;
        reset   = 1'b1;
        tick();
        reset = 1'b0;
        compared++;
        if (outValid !== 1'b0) begin mismatched++; $display("[TB] FAIL rmid out_valid: got %b want 0", outValid); end
        compared++;
        if (outData !== 8'h00) begin mismatched++; $display("[TB] FAIL rmid out_data: got %h want 00", outData); end
        compared++;
        if (outErr !== 1'b0) begin mismatched++; $display("[TB] FAIL rmid out_err: got %b want 0", outErr); end
        compared++;
        if (errCnt !== 2'd0) begin mismatched++; $display("[TB] FAIL rmid err_cnt: got %0d want 0", errCnt); end
        compared++;
        if (inReady !== 1'b1) begin mismatched++; $display("[TB] FAIL rmid in_ready: got %b want 1", inReady); end
        outReady = 1'b1;
        inValid  = 1'b1;
        parImpar = 1'b1;
        inData   = 7'h03;
        tick();
        inValid = 1'b0;
        compared++;
        if (outValid !== 1'b1) begin mismatched++; $display("[TB] FAIL rmid_next out_valid: got %b want 1", outValid); end
        compared++;
        if (outData !== 8'h83) begin mismatched++; $display("[TB] FAIL rmid_next out_data: got %h want 83", outData); end
        tick();
    endtask

    task automatic test_back_to_back();
        logic [DATA_W-1:0] words [4];
        logic              modes [4];
        logic [DATA_W:0]   wants [4];
        words = '{7'h00, 7'h7F, 7'h2A, 7'h40};
        modes = '{1'b0, 1'b0, 1'b1, 1'b1};
        wants = '{8'h00, 8'hFF, 8'h2A, 8'h40};
        outReady = 1'b1;
        inValid  = 1'b1;
        inChk    = 1'b0;
        for (int i = 0; i < 4; i++) begin
            inData   = words[i];
            parImpar = modes[i];
            tick();
            compared++;
            if (outData !== wants[i] || outValid !== 1'b1) begin
                mismatched++;
                $display("[TB] FAIL b2b_word%0d out_data/valid: got %h/%b want %h/1", i, outData, outValid, wants[i]);
            end
            compared++;
            if (inReady !== 1'b1) begin mismatched++; $display("[TB] FAIL b2b_word%0d in_ready: got %b want 1", i, inReady); end
        end
        inValid = 1'b0;
        tick();
    endtask

    initial begin
        $display("[TB] start, counter feature = %0d", CntEn);
        test_reset();
        test_generate();
        test_back_pressure();
        test_check();
        test_saturation();
        test_reset_mid();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
